// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads the PC address, fetches from instruction memory over req/ack,
// and hands the word to decode with valid/ready. Holds the PC via pc_stall while a fetch is pending.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_addr,
  output logic               pc_stall,
  input  logic               flush,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_addr,
  output logic               fetch_err,
  output logic [15:0]        fetch_count
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    ERR
  } state_t;

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

  state_t     state;
  logic [7:0] tmo_cnt;
  logic [7:0] tmo_next;

  assign tmo_next = tmo_cnt + 8'd1;

  // The only cycle the PC may advance is the one in which decode takes the held word.
  assign pc_stall = !((state == HOLD) && instr_ready && !flush);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      instr_valid <= 1'b0;
      instr_out   <= '0;
      instr_addr  <= '0;
      fetch_err   <= 1'b0;
      fetch_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          mem_req  <= 1'b1;
          mem_addr <= pc_addr;
          tmo_cnt  <= '0;
        end

        REQ: begin
          // Flush outranks a coincident ack; an ack outranks a coincident timeout.
          if (flush) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            tmo_cnt <= '0;
          end else if (mem_ack) begin
            state       <= HOLD;
            mem_req     <= 1'b0;
            instr_out   <= mem_rdata;
            instr_addr  <= mem_addr;
            instr_valid <= 1'b1;
            tmo_cnt     <= '0;
          end else if (tmo_next == TMO_LIMIT) begin
            state     <= ERR;
            mem_req   <= 1'b0;
            fetch_err <= 1'b1;
            tmo_cnt   <= tmo_next;
          end else begin
            tmo_cnt <= tmo_next;
          end
        end

        HOLD: begin
          if (flush) begin
            state       <= IDLE;
            instr_valid <= 1'b0;
          end else if (instr_ready) begin
            state       <= REQ;
            mem_req     <= 1'b1;
            mem_addr    <= pc_addr;
            instr_valid <= 1'b0;
            fetch_count <= fetch_count + 16'd1;
            tmo_cnt     <= '0;
          end
        end

        ERR: begin
          mem_req     <= 1'b0;
          instr_valid <= 1'b0;
          fetch_err   <= 1'b1;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
